// File: rtl/nibble_mem_responder_if.sv
// Nibble memory bus bundle: initiator nibble handshake plus the responder's SRAM port.
// master = core controller / SRAM side, slave = nibble_mem_responder.
interface nibble_mem_responder_if #(
  parameter int ADDR_W = 24
);
  logic              req;
  logic              we;
  logic [1:0]        memType;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        nibIn;
  logic              nibVld;
  logic [3:0]        nibOut;
  logic              nibOe;
  logic [2:0]        dataPos;
  logic              memGet;
  logic              memReady;
  logic              busy;
  logic              err;
  logic [ADDR_W-3:0] sramAddr;
  logic              sramRe;
  logic              sramWe;
  logic [3:0]        sramBe;
  logic [31:0]       sramWdata;
  logic [31:0]       sramRdata;

  modport master (
    output req, we, memType, addr, nibIn, nibVld, sramRdata,
    input  nibOut, nibOe, dataPos, memGet, memReady, busy, err,
           sramAddr, sramRe, sramWe, sramBe, sramWdata
  );

  modport slave (
    input  req, we, memType, addr, nibIn, nibVld, sramRdata,
    output nibOut, nibOe, dataPos, memGet, memReady, busy, err,
           sramAddr, sramRe, sramWe, sramBe, sramWdata
  );
endinterface

// File: rtl/nibble_mem_responder.sv
// Nibble-serial memory responder in front of a word-wide single-port SRAM.
// Define NIBMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses with err.
module nibble_mem_responder #(
  parameter int ADDR_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_mem_responder_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD_REQ     = 3'd1,
    S_RD_WAIT    = 3'd2,
    S_RD_SEND    = 3'd3,
    S_WR_COLLECT = 3'd4,
    S_WR_COMMIT  = 3'd5,
    S_DONE       = 3'd6
  } state_e;

  function automatic logic [2:0] last_idx(input logic [1:0] sz);
    case (sz)
      2'b01:   last_idx = 3'd1;
      2'b10:   last_idx = 3'd3;
      default: last_idx = 3'd7;
    endcase
  endfunction

  // Slot order interleaves low/high nibble of each byte position code.
  function automatic logic [2:0] pos_code(input logic [2:0] idx);
    pos_code = {idx[0], idx[2:1]};
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b01:   size_mask = 32'h0000_00FF;
      2'b10:   size_mask = 32'h0000_FFFF;
      default: size_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [1:0] lane(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b01:   lane = lo;
      2'b10:   lane = {lo[1], 1'b0};
      default: lane = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] sh);
    case (sz)
      2'b01:   byte_en = 4'b0001 << sh;
      2'b10:   byte_en = 4'b0011 << sh;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        sh_q, sh_d;
  logic [2:0]        idx_q, idx_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [3:0]        nib_out_q, nib_out_d;
  logic              nib_oe_q, nib_oe_d;
  logic [2:0]        data_pos_q, data_pos_d;
  logic              mem_get_q, mem_get_d;
  logic              mem_ready_q, mem_ready_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-3:0] sram_addr_q, sram_addr_d;
  logic              sram_re_q, sram_re_d;
  logic              sram_we_q, sram_we_d;
  logic [3:0]        sram_be_q, sram_be_d;
  logic [31:0]       sram_wdata_q, sram_wdata_d;
  logic [1:0]        req_size_s;
  logic [31:0]       rdata_s;
  logic              reject_s;

  assign req_size_s = (bus.memType == 2'b00) ? 2'b11 : bus.memType;
  assign rdata_s    = (bus.sramRdata >> {sh_q, 3'b000}) & size_mask(size_q);

`ifdef NIBMEM_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign reject_s = ((req_size_s == 2'b10) && bus.addr[0]) ||
                    ((req_size_s == 2'b11) && (bus.addr[1:0] != 2'b00));
  assign bus.err  = err_q;
`else
  assign reject_s = 1'b0;
  assign bus.err  = 1'b0;
`endif

  // Next-state and next-output computation for the whole transaction sequencer.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    sh_d         = sh_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    wbuf_d       = wbuf_q;
    nib_out_d    = 4'h0;
    nib_oe_d     = 1'b0;
    data_pos_d   = data_pos_q;
    mem_get_d    = 1'b0;
    mem_ready_d  = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_re_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_be_d    = 4'h0;
    sram_wdata_d = 32'h0;
`ifdef NIBMEM_ALIGN_CHECK_EN
    err_d        = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          size_d      = req_size_s;
          sh_d        = lane(req_size_s, bus.addr[1:0]);
          sram_addr_d = bus.addr[ADDR_W-1:2];
          idx_d       = 3'd0;
          data_pos_d  = 3'd0;
          wbuf_d      = 32'h0;
          shreg_d     = 32'h0;
          if (reject_s) begin
            state_d = S_DONE;
          end else if (bus.we) begin
            state_d   = S_WR_COLLECT;
            mem_get_d = 1'b1;
          end else begin
            state_d   = S_RD_REQ;
            sram_re_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        nib_out_d  = rdata_s[3:0];
        nib_oe_d   = 1'b1;
        shreg_d    = {4'h0, rdata_s[31:4]};
        idx_d      = 3'd0;
        data_pos_d = 3'd0;
        state_d    = S_RD_SEND;
      end
      S_RD_SEND: begin
        if (idx_q == last_idx(size_q)) begin
          state_d     = S_DONE;
          mem_ready_d = 1'b1;
          idx_d       = 3'd0;
          data_pos_d  = 3'd0;
        end else begin
          idx_d      = idx_q + 3'd1;
          nib_out_d  = shreg_q[3:0];
          nib_oe_d   = 1'b1;
          shreg_d    = {4'h0, shreg_q[31:4]};
          data_pos_d = pos_code(idx_q + 3'd1);
        end
      end
      S_WR_COLLECT: begin
        if (bus.nibVld) begin
          wbuf_d[{idx_q, 2'b00} +: 4] = bus.nibIn;
          if (idx_q == last_idx(size_q)) begin
            state_d      = S_WR_COMMIT;
            sram_we_d    = 1'b1;
            sram_be_d    = byte_en(size_q, sh_q);
            sram_wdata_d = wbuf_d << {sh_q, 3'b000};
            idx_d        = 3'd0;
            data_pos_d   = 3'd0;
          end else begin
            idx_d      = idx_q + 3'd1;
            data_pos_d = pos_code(idx_q + 3'd1);
            mem_get_d  = 1'b1;
          end
        end else begin
          mem_get_d = 1'b1;
        end
      end
      S_WR_COMMIT: begin
        state_d     = S_DONE;
        mem_ready_d = 1'b1;
      end
      S_DONE: begin
        // A rejected request arrives here without the pulse and raises it one cycle later.
        if (mem_ready_q) begin
          state_d = S_IDLE;
        end else begin
          mem_ready_d = 1'b1;
`ifdef NIBMEM_ALIGN_CHECK_EN
          err_d       = 1'b1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      size_q       <= 2'b00;
      sh_q         <= 2'b00;
      idx_q        <= 3'd0;
      shreg_q      <= 32'h0;
      wbuf_q       <= 32'h0;
      nib_out_q    <= 4'h0;
      nib_oe_q     <= 1'b0;
      data_pos_q   <= 3'd0;
      mem_get_q    <= 1'b0;
      mem_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      sram_addr_q  <= '0;
      sram_re_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_be_q    <= 4'h0;
      sram_wdata_q <= 32'h0;
`ifdef NIBMEM_ALIGN_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      sh_q         <= sh_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      wbuf_q       <= wbuf_d;
      nib_out_q    <= nib_out_d;
      nib_oe_q     <= nib_oe_d;
      data_pos_q   <= data_pos_d;
      mem_get_q    <= mem_get_d;
      mem_ready_q  <= mem_ready_d;
      busy_q       <= busy_d;
      sram_addr_q  <= sram_addr_d;
      sram_re_q    <= sram_re_d;
      sram_we_q    <= sram_we_d;
      sram_be_q    <= sram_be_d;
      sram_wdata_q <= sram_wdata_d;
`ifdef NIBMEM_ALIGN_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  assign bus.nibOut    = nib_out_q;
  assign bus.nibOe     = nib_oe_q;
  assign bus.dataPos   = data_pos_q;
  assign bus.memGet    = mem_get_q;
  assign bus.memReady  = mem_ready_q;
  assign bus.busy      = busy_q;
  assign bus.sramAddr  = sram_addr_q;
  assign bus.sramRe    = sram_re_q;
  assign bus.sramWe    = sram_we_q;
  assign bus.sramBe    = sram_be_q;
  assign bus.sramWdata = sram_wdata_q;
endmodule

// File: tb/tb_nibble_mem_responder.sv
// Randomized self-checking bench for nibble_mem_responder against a word-array memory model.
// Follows NIBMEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_nibble_mem_responder;
  logic clk;
  logic rst;
  logic sram_clr;
  bit   align_on;
  int   n_checks;
  int   n_fail;
  logic [31:0] ref_mem [0:255];
  logic [31:0] sram    [0:255];
  int   pos_tab [0:7];

  nibble_mem_responder_if #(.ADDR_W(24)) bus ();

  nibble_mem_responder #(.ADDR_W(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-wide synchronous SRAM: read data appears the cycle after sramRe.
  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < 256; i++) sram[i] <= 32'h0;
    end else begin
      if (bus.sramRe) bus.sramRdata <= sram[bus.sramAddr[7:0]];
      if (bus.sramWe) begin
        for (int b = 0; b < 4; b++)
          if (bus.sramBe[b]) sram[bus.sramAddr[7:0]][8*b +: 8] <= bus.sramWdata[8*b +: 8];
      end
    end
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] out_pack();
    out_pack = {56'd0, bus.nibOut, bus.nibOe, bus.dataPos, bus.memGet, bus.memReady, bus.busy,
                bus.err, bus.sramAddr, bus.sramRe, bus.sramWe, bus.sramBe, bus.sramWdata};
  endfunction

  function automatic int size_of(input logic [1:0] mt);
    return (mt == 2'b00) ? 3 : int'(mt);
  endfunction

  function automatic int lane_of(input int sz, input logic [23:0] a);
    if (sz == 1) return int'(a[1:0]);
    if (sz == 2) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic bit misaligned(input int sz, input logic [23:0] a);
    return (sz == 2 && a[0]) || (sz == 3 && a[1:0] != 2'b00);
  endfunction

  task automatic do_load(input logic [1:0] mt, input logic [23:0] a, input bit b2b);
    int sz, n, sh, ready_cyc, nib_cnt, re_cnt;
    bit rej;
    logic [31:0] mask, exp_val;
    sz = size_of(mt);
    n = 1 << sz;
    sh = lane_of(sz, a);
    rej = align_on && misaligned(sz, a);
    mask = (sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    exp_val = (ref_mem[a[9:2]] >> (8 * sh)) & mask;
    ready_cyc = 0; nib_cnt = 0; re_cnt = 0;
    if (!b2b) @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.memType = mt; bus.addr = a;
    if (b2b) begin
      @(posedge clk); @(negedge clk);
      check_val("b2b_req_ignored", 128'(bus.busy), 128'(0));
    end
    @(posedge clk); @(negedge clk);
    bus.req = 1'b0;
    for (int cyc = 1; cyc <= 40 && ready_cyc == 0; cyc++) begin
      if (bus.sramRe) begin
        re_cnt++;
        check_val("rd_re_cycle", 128'(cyc), 128'(1));
      end
      if (bus.nibOe) begin
        if (nib_cnt < 8) begin
          check_val("rd_nib", 128'(bus.nibOut), 128'((exp_val >> (4 * nib_cnt)) & 32'hF));
          check_val("rd_pos", 128'(bus.dataPos), 128'(pos_tab[nib_cnt]));
          check_val("rd_nib_cyc", 128'(cyc), 128'(3 + nib_cnt));
        end
        nib_cnt++;
      end
      if (bus.memReady) begin
        ready_cyc = cyc;
        check_val("rd_err", 128'(bus.err), 128'(rej));
      end else begin
        @(negedge clk);
      end
    end
    check_val("rd_ready_cyc", 128'(ready_cyc), 128'(rej ? 2 : 3 + n));
    check_val("rd_nib_count", 128'(nib_cnt), 128'(rej ? 0 : n));
    check_val("rd_re_count", 128'(re_cnt), 128'(rej ? 0 : 1));
  endtask

  task automatic do_store(input logic [1:0] mt, input logic [23:0] a, input logic [31:0] d,
                          input int gap_at, input int gap_len);
    int sz, n, sh, ready_cyc, we_cnt, sent, gap_left, gap_eff;
    bit rej, exp_get;
    logic [31:0] mask, dm, exp_wdata;
    logic [3:0] exp_be;
    sz = size_of(mt);
    n = 1 << sz;
    sh = lane_of(sz, a);
    rej = align_on && misaligned(sz, a);
    mask = (sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    dm = d & mask;
    exp_wdata = dm << (8 * sh);
    exp_be = ((sz == 1) ? 4'b0001 : (sz == 2) ? 4'b0011 : 4'b1111) << sh;
    gap_eff = (gap_at < n) ? gap_len : 0;
    ready_cyc = 0; we_cnt = 0; sent = 0; gap_left = gap_len;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.memType = mt; bus.addr = a;
    @(posedge clk); @(negedge clk);
    bus.req = 1'b0;
    for (int cyc = 1; cyc <= 60 && ready_cyc == 0; cyc++) begin
      exp_get = !rej && (sent < n);
      check_val("wr_mem_get", 128'(bus.memGet), 128'(exp_get));
      if (bus.sramWe) begin
        we_cnt++;
        check_val("wr_we_cyc", 128'(cyc), 128'(n + 1 + gap_eff));
        check_val("wr_be", 128'(bus.sramBe), 128'(exp_be));
        check_val("wr_wdata", 128'(bus.sramWdata), 128'(exp_wdata));
        check_val("wr_addr", 128'(bus.sramAddr), 128'(a[23:2]));
      end
      if (exp_get && sent == gap_at && gap_left > 0) begin
        bus.nibVld = 1'b0;
        gap_left--;
      end else if (exp_get) begin
        bus.nibVld = 1'b1;
        bus.nibIn = dm[4*sent +: 4];
        sent++;
      end else begin
        bus.nibVld = 1'b0;
      end
      if (bus.memReady) begin
        ready_cyc = cyc;
        check_val("wr_err", 128'(bus.err), 128'(rej));
      end else begin
        @(negedge clk);
      end
    end
    bus.nibVld = 1'b0;
    check_val("wr_ready_cyc", 128'(ready_cyc), 128'(rej ? 2 : n + 2 + gap_eff));
    check_val("wr_we_count", 128'(we_cnt), 128'(rej ? 0 : 1));
    if (!rej) begin
      for (int b = 0; b < 4; b++)
        if (exp_be[b]) ref_mem[a[9:2]][8*b +: 8] = exp_wdata[8*b +: 8];
    end
  endtask

  initial begin
    int nib_seen, rdy_seen;
    logic [1:0] mt;
    logic [23:0] a;
    n_checks = 0; n_fail = 0;
    align_on = 1'b0;
`ifdef NIBMEM_ALIGN_CHECK_EN
    align_on = 1'b1;
`endif
    pos_tab = '{0, 4, 1, 5, 2, 6, 3, 7};
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    rst = 1'b1; sram_clr = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.memType = 2'b00; bus.addr = 24'h0;
    bus.nibIn = 4'h0; bus.nibVld = 1'b0; bus.sramRdata = 32'h0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", out_pack(), 128'(0));
    rst = 1'b0; sram_clr = 1'b0;

    // Directed cases from the feature list.
    do_store(2'b11, 24'h000008, 32'hDEADBEEF, 99, 0);
    do_load(2'b11, 24'h000008, 1'b0);
    do_load(2'b01, 24'h00000A, 1'b0);
    do_store(2'b10, 24'h000006, 32'h00001234, 99, 0);
    do_store(2'b11, 24'h000010, 32'hA5C3_9E71, 3, 3);
    do_load(2'b11, 24'h000010, 1'b1);
    do_load(2'b11, 24'h000002, 1'b0);
    do_load(2'b00, 24'h000006, 1'b1);

    // Reset asserted after the fourth nibble of a word read.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.memType = 2'b11; bus.addr = 24'h000008;
    @(posedge clk); @(negedge clk);
    bus.req = 1'b0;
    nib_seen = 0;
    for (int c = 0; c < 20 && nib_seen < 4; c++) begin
      if (bus.nibOe) nib_seen++;
      if (nib_seen < 4) @(negedge clk);
    end
    check_val("rst_nibs_before", 128'(nib_seen), 128'(4));
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_outputs", out_pack(), 128'(0));
    rst = 1'b0;
    rdy_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.memReady || bus.busy) rdy_seen++;
    end
    check_val("rst_no_ready", 128'(rdy_seen), 128'(0));
    do_load(2'b11, 24'h000008, 1'b0);

    // Random mix of loads and stores.
    for (int it = 0; it < 40; it++) begin
      mt = 2'($urandom_range(0, 3));
      a = 24'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 2) == 0)
          do_store(mt, a, $urandom, int'($urandom_range(0, 7)), int'($urandom_range(1, 4)));
        else
          do_store(mt, a, $urandom, 99, 0);
      end else begin
        do_load(mt, a, 1'($urandom_range(0, 1)));
      end
    end
    for (int w = 0; w < 4; w++) do_load(2'b11, 24'(w * 4), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nibble_mem_responder.md
# nibble_mem_responder

Memory-side responder for the core's 4-bit nibble memory bus. Accepts a request (address, size, direction) from the core memory controller, serialises read data out nibble-by-nibble or collects write nibbles, and performs the access on a single-port, word-wide synchronous SRAM. It sits between the core memory controller and the on-chip instruction/data SRAM and terminates the protocol that controller initiates.

## Interface
- `ADDR_W`, 24: byte address width on the bus side.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: request strobe; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load; sampled with `req`.
- `memType` in 2: 01 byte, 10 halfword, 11 word; 00 treated as word.
- `addr` in ADDR_W: byte address; sampled with `req`.
- `nibIn` in 4, `nibVld` in 1: write nibble from the initiator and its valid.
- `nibOut` out 4, `nibOe` out 1: read nibble and bus-drive enable.
- `dataPos` out 3: position code of the current nibble.
- `memGet` out 1: responder ready for the next write nibble.
- `memReady` out 1: one-cycle completion pulse.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: valid with `memReady`; see Configuration.
- `sramAddr` out ADDR_W-2: word address.
- `sramRe`, `sramWe` out 1: read/write strobes.
- `sramBe` out 4: write byte enables.
- `sramWdata` out 32: write data.
- `sramRdata` in 32: read data, valid the cycle after `sramRe`.

## Operation
- Nibble order, fixed: `dataPos` codes 000,100,001,101,010,110,011,111 carry bits [3:0],[7:4],[11:8],[15:12],[19:16],[23:20],[27:24],[31:28]. Nibble count N = 2/4/8 for byte/half/word. Sequence always starts at 000.
- Lane: `sh = addr[1:0]`. Halfword uses `addr[1]` only. Read data is `sramRdata >> 8*sh`, with bits above the size cleared. Write data is `wbuf << 8*sh`, with `sramBe` = 0001/0011/1111 shifted by `sh`.
- States:
  - IDLE: `req` → RD_REQ (we=0) or WR_COLLECT (we=1); latch `addr`, `memType`, `we`.
  - RD_REQ: `sramRe`=1 one cycle → RD_WAIT.
  - RD_WAIT: capture shifted `sramRdata` into shift register → RD_SEND.
  - RD_SEND: `nibOe`=1, one nibble per cycle, `dataPos` advances; after nibble N → DONE.
  - WR_COLLECT: `memGet`=1. Each cycle with `nibVld`=1 stores `nibIn` at the current `dataPos` slot and advances. After N nibbles → WR_COMMIT. `nibVld` low stalls indefinitely.
  - WR_COMMIT: `sramWe`=1 one cycle with `sramBe`, `sramWdata` → DONE.
  - DONE: `memReady`=1 one cycle → IDLE.
- `req` outside IDLE is ignored; no queueing.
- Reset values: all outputs 0, state IDLE, `dataPos` 000, buffers 0.
- Reset mid-operation: immediate return to IDLE. An SRAM write not yet in WR_COMMIT is never issued, and no `memReady` is produced.

## Timing
- Load: `req` sampled at edge 0. `sramRe` high in cycle 1, capture at edge 2, nibbles in cycles 3…2+N, `memReady` in cycle 3+N. Word read: `memReady` 11 cycles after `req`.
- Store with `nibVld` held high: nibbles accepted at edges 1…N, `sramWe` in cycle N+1, `memReady` in cycle N+2.
- `req` may reassert in the same cycle `memReady` is high; it is sampled at the edge returning to IDLE and ignored. It is accepted from the following edge.
- All outputs are registered; no combinational input→output path.

## Configuration
- `NIBMEM_ALIGN_CHECK_EN` defined:
  - Halfword with `addr[0]`=1, or word with `addr[1:0]`≠0, goes IDLE → DONE directly.
  - No SRAM strobe, no nibbles, `memGet` stays 0.
  - `memReady`=1 with `err`=1 (2-cycle latency).
- Undefined: misaligned low bits are forced to 0 (half: bit 0, word: bits 1:0) and the access proceeds. `err` is tied 0.

## Test plan
- Preload word 0x2 = 0xDEADBEEF. Load word, addr 0x000008 → `nibOut` F,E,E,B,D,A,E,D with `dataPos` 000,100,001,101,010,110,011,111; `memReady` at cycle 11, `err` 0.
- Load byte, addr 0x00000A, same word → nibbles D,A (value 0xAD); `memReady` at cycle 5.
- Store half 0x1234 to 0x000006 with `nibVld` high → `sramBe` 1100, `sramWdata` 0x12340000, `sramAddr` 0x1; `memReady` at cycle 6.
- Store word with `nibVld` gapped (low 3 cycles after nibble 3) → `memGet` stays high; commit is delayed exactly 3 cycles; data correct.
- Assert `rst` during RD_SEND after nibble 4 → next cycle all outputs 0, state IDLE, no `memReady`. A subsequent read completes normally.
- Load word addr 0x000002: with `NIBMEM_ALIGN_CHECK_EN` → `memReady`+`err` at cycle 2, `sramRe` never high. Without it → reads word 0x0, `err` 0.
